// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit and the CPU control unit that issues its ops.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mult_div_unit_abs_negate.sv
// Conditional two's-complement negate: used both to take operand magnitudes and to re-apply result signs.
module abs_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? -in_val : in_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle on operand magnitudes, followed by a single sign-fix cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;

    logic               in_is_div;
    logic               in_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;

    assign in_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign in_signed = (op == OP_MULT) || (op == OP_DIV);

    abs_negate #(.WIDTH(WIDTH)) u_abs_a (
        .in_val (a),
        .neg    (in_signed & a[WIDTH-1]),
        .out_val(mag_a)
    );

    abs_negate #(.WIDTH(WIDTH)) u_abs_b (
        .in_val (b),
        .neg    (in_signed & b[WIDTH-1]),
        .out_val(mag_b)
    );

    abs_negate #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .in_val ({acc_hi_q, acc_lo_q}),
        .neg    (neg_res_q),
        .out_val(prod_fixed)
    );

    abs_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .in_val (acc_lo_q),
        .neg    (neg_res_q),
        .out_val(quo_fixed)
    );

    abs_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .in_val (acc_hi_q),
        .neg    (neg_rem_q),
        .out_val(rem_fixed)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;

        // The carry out of the add is kept as bit WIDTH so the right shift loses nothing.
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_diff = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opb_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    is_div_d   = in_is_div;
                    neg_res_d  = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = in_signed & a[WIDTH-1];
                    acc_hi_d   = '0;
                    acc_lo_d   = in_is_div ? mag_a : mag_b;
                    opb_d      = in_is_div ? mag_b : mag_a;
                    if (in_is_div && (b == '0)) begin
                        hi_d       = a;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                hi_d    = is_div_q ? rem_fixed : prod_fixed[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? quo_fixed : prod_fixed[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Working datapath carries no reset; it is always reloaded on an accepted start.
    always_ff @(posedge clock) begin
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        acc_hi_q  <= acc_hi_d;
        acc_lo_q  <= acc_lo_d;
        opb_q     <= opb_d;
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign div_zero = div_zero_q;

endmodule
